// File: rtl/fetch_pkg.sv
// Shared defaults and state encoding for the instruction-fetch sequencer.
package fetch_pkg;

  localparam int ADDR_W_DEF    = 6;
  localparam int DATA_W_DEF    = 32;
  localparam int ROM_DEPTH_DEF = 12;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_e;

endpackage

// File: rtl/fetch_perf_counter.sv
// 16-bit saturating event counter with synchronous clear; clear wins over increment.
module fetch_perf_counter
  import fetch_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        inc,
  input  logic        clr,
  output logic [15:0] count
);

  logic [15:0] cnt_q;
  logic [15:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc && (cnt_q != 16'hFFFF)) begin
      cnt_d = cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign count = cnt_q;

endmodule

// File: rtl/fetch_sequencer.sv
// Instruction-fetch controller: owns the PC, drives the ROM address and hands words to decode.
// Define FETCH_SEQ_PERF_EN to build the back-pressure stall counter behind perf_stall_cnt.
module fetch_sequencer
  import fetch_pkg::*;
#(
  parameter int ADDR_W    = ADDR_W_DEF,
  parameter int DATA_W    = DATA_W_DEF,
  parameter int ROM_DEPTH = ROM_DEPTH_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [DATA_W-1:0] rom_data,
  output logic [DATA_W-1:0] ir,
  output logic [ADDR_W-1:0] ir_pc,
  output logic              ir_valid,
  input  logic              ir_ready,
  input  logic              br_valid,
  input  logic [ADDR_W-1:0] br_target,
  output logic              busy,
  output logic              done,
  output logic [15:0]       perf_stall_cnt
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(ROM_DEPTH - 1);
  localparam logic [ADDR_W:0]   DEPTH_X   = (ADDR_W + 1)'(ROM_DEPTH);

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   rom_addr_q, rom_addr_d;
  logic [DATA_W-1:0]   ir_q, ir_d;
  logic [ADDR_W-1:0]   ir_pc_q, ir_pc_d;
  logic                ir_valid_q, ir_valid_d;
  logic                adv;
  logic                in_flight;
  logic                br_in_range;

  assign adv         = !ir_valid_q || ir_ready;
  assign in_flight   = (state_q == FETCH) || (state_q == DRAIN);
  assign br_in_range = ({1'b0, br_target} < DEPTH_X);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rom_addr_q <= '0;
      ir_q       <= '0;
      ir_pc_q    <= '0;
      ir_valid_q <= 1'b0;
    end else begin
      rom_addr_q <= rom_addr_d;
      ir_q       <= ir_d;
      ir_pc_q    <= ir_pc_d;
      ir_valid_q <= ir_valid_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    rom_addr_d = rom_addr_q;
    ir_d       = ir_q;
    ir_pc_d    = ir_pc_q;
    ir_valid_d = ir_valid_q;
    unique case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d    = FETCH;
          rom_addr_d = '0;
        end
      end
      FETCH: begin
        if (adv) begin
          ir_d       = rom_data;
          ir_pc_d    = rom_addr_q;
          ir_valid_d = 1'b1;
          if (rom_addr_q == LAST_ADDR) begin
            state_d = DRAIN;
          end else begin
            rom_addr_d = rom_addr_q + 1'b1;
          end
        end
      end
      DRAIN: begin
        if (ir_valid_q && ir_ready) begin
          ir_valid_d = 1'b0;
          state_d    = DONE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // A redirect flushes the in-flight word and overrides any capture made above.
    if (in_flight && br_valid) begin
      ir_d       = ir_q;
      ir_pc_d    = ir_pc_q;
      ir_valid_d = 1'b0;
      if (br_in_range) begin
        rom_addr_d = br_target;
        state_d    = FETCH;
      end else begin
        rom_addr_d = rom_addr_q;
        state_d    = DONE;
      end
    end
  end

  always_comb begin
    busy = (state_q == FETCH) || (state_q == DRAIN);
    done = (state_q == DONE);
  end

  assign rom_addr = rom_addr_q;
  assign ir       = ir_q;
  assign ir_pc    = ir_pc_q;
  assign ir_valid = ir_valid_q;

`ifdef FETCH_SEQ_PERF_EN
  logic start_accepted;
  logic stall_cycle;

  assign start_accepted = start && ((state_q == IDLE) || (state_q == DONE));
  assign stall_cycle    = in_flight && ir_valid_q && !ir_ready;

  fetch_perf_counter u_perf_counter (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (stall_cycle),
    .clr   (start_accepted),
    .count (perf_stall_cnt)
  );
`else
  assign perf_stall_cnt = '0;
`endif

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer; ROM returns 32'h1000_0000 + address, read on the falling edge.
module tb_fetch_sequencer;

  localparam int AW    = 6;
  localparam int DW    = 32;
  localparam int DEPTH = 12;
`ifdef FETCH_SEQ_PERF_EN
  localparam int PERF_ON = 1;
`else
  localparam int PERF_ON = 0;
`endif

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic [AW-1:0] rom_addr;
  logic [DW-1:0] rom_data;
  logic [DW-1:0] ir;
  logic [AW-1:0] ir_pc;
  logic          ir_valid;
  logic          ir_ready;
  logic          br_valid;
  logic [AW-1:0] br_target;
  logic          busy;
  logic          done;
  logic [15:0]   perf_stall_cnt;

  int tests_run    = 0;
  int tests_failed = 0;

  int          acc_pc[$];
  logic [31:0] acc_ir[$];
  int          max_addr;
  int          last_gap;
  bit          reached_done;

  fetch_sequencer #(.ADDR_W(AW), .DATA_W(DW), .ROM_DEPTH(DEPTH)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .start          (start),
    .rom_addr       (rom_addr),
    .rom_data       (rom_data),
    .ir             (ir),
    .ir_pc          (ir_pc),
    .ir_valid       (ir_valid),
    .ir_ready       (ir_ready),
    .br_valid       (br_valid),
    .br_target      (br_target),
    .busy           (busy),
    .done           (done),
    .perf_stall_cnt (perf_stall_cnt)
  );

  always #5 clk = ~clk;

  always @(negedge clk) rom_data <= 32'h1000_0000 + {26'd0, rom_addr};

  function automatic logic [31:0] word_at(input int a);
    return 32'h1000_0000 + a;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    start     = 1'b0;
    ir_ready  = 1'b0;
    br_valid  = 1'b0;
    br_target = '0;
    step();
    step();
    rst_n = 1'b1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic run_to_pc(input int pc, output bit found);
    found    = 1'b0;
    ir_ready = 1'b1;
    for (int i = 0; i < 40; i++) begin
      if (ir_valid && (int'(ir_pc) == pc)) begin
        found = 1'b1;
        break;
      end
      step();
    end
  endtask

  // Consumes words with ir_ready high until done, recording each handshake.
  task automatic drain_accept();
    int last_i;
    acc_pc.delete();
    acc_ir.delete();
    reached_done = 1'b0;
    last_gap     = -1;
    last_i       = -1;
    ir_ready     = 1'b1;
    for (int i = 0; i < 60; i++) begin
      if (int'(rom_addr) > max_addr) max_addr = int'(rom_addr);
      if (done) begin
        reached_done = 1'b1;
        last_gap     = i - last_i;
        break;
      end
      if (ir_valid && ir_ready) begin
        acc_pc.push_back(int'(ir_pc));
        acc_ir.push_back(ir);
        last_i = i;
      end
      step();
    end
  endtask

  task automatic test_reset();
    do_reset();
    tests_run++;
    if (rom_addr !== '0) begin
      tests_failed++;
      $display("[TB] FAIL reset_rom_addr: got %0h, want 0", rom_addr);
    end
    tests_run++;
    if ((ir !== '0) || (ir_pc !== '0) || (ir_valid !== 1'b0)) begin
      tests_failed++;
      $display("[TB] FAIL reset_ir: got ir=%0h pc=%0h v=%0b, want 0/0/0", ir, ir_pc, ir_valid);
    end
    tests_run++;
    if ((busy !== 1'b0) || (done !== 1'b0) || (perf_stall_cnt !== 16'd0)) begin
      tests_failed++;
      $display("[TB] FAIL reset_status: got busy=%0b done=%0b perf=%0d, want 0/0/0", busy, done, perf_stall_cnt);
    end
    br_valid  = 1'b1;
    br_target = 6'd3;
    ir_ready  = 1'b1;
    step();
    br_valid = 1'b0;
    tests_run++;
    if ((busy !== 1'b0) || (rom_addr !== '0) || (ir_valid !== 1'b0)) begin
      tests_failed++;
      $display("[TB] FAIL idle_ignores_branch: got busy=%0b addr=%0d v=%0b, want 0/0/0", busy, rom_addr, ir_valid);
    end
  endtask

  task automatic test_straight_line();
    do_reset();
    ir_ready = 1'b1;
    max_addr = 0;
    pulse_start();
    tests_run++;
    if ((rom_addr !== 6'd0) || (busy !== 1'b1) || (ir_valid !== 1'b0)) begin
      tests_failed++;
      $display("[TB] FAIL start_latency: got addr=%0d busy=%0b v=%0b, want 0/1/0", rom_addr, busy, ir_valid);
    end
    step();
    tests_run++;
    if ((ir_valid !== 1'b1) || (ir_pc !== 6'd0) || (ir !== word_at(0))) begin
      tests_failed++;
      $display("[TB] FAIL first_word: got v=%0b pc=%0d ir=%0h, want 1/0/10000000", ir_valid, ir_pc, ir);
    end
    drain_accept();
    tests_run++;
    if ((reached_done !== 1'b1) || (acc_pc.size() != DEPTH)) begin
      tests_failed++;
      $display("[TB] FAIL straight_count: got done=%0b n=%0d, want 1/%0d", reached_done, acc_pc.size(), DEPTH);
    end
    for (int k = 0; k < DEPTH; k++) begin
      tests_run++;
      if ((k >= acc_pc.size()) || (acc_pc[k] != k) || (acc_ir[k] !== word_at(k))) begin
        tests_failed++;
        $display("[TB] FAIL straight_word_%0d: got pc=%0d ir=%0h, want pc=%0d ir=%0h", k,
                 (k < acc_pc.size()) ? acc_pc[k] : -1, (k < acc_ir.size()) ? acc_ir[k] : 32'hx, k, word_at(k));
      end
    end
    tests_run++;
    if ((last_gap != 1) || (ir_valid !== 1'b0) || (busy !== 1'b0)) begin
      tests_failed++;
      $display("[TB] FAIL done_timing: got gap=%0d v=%0b busy=%0b, want 1/0/0", last_gap, ir_valid, busy);
    end
    tests_run++;
    if (max_addr > DEPTH - 1) begin
      tests_failed++;
      $display("[TB] FAIL rom_addr_bound: got max %0d, want <= %0d", max_addr, DEPTH - 1);
    end
  endtask

  task automatic test_back_pressure();
    bit found;
    do_reset();
    ir_ready = 1'b1;
    pulse_start();
    run_to_pc(4, found);
    tests_run++;
    if (found !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL bp_reach_pc4: got found=%0b, want 1", found);
    end
    ir_ready = 1'b0;
    for (int s = 0; s < 3; s++) begin
      step();
      tests_run++;
      if ((ir !== word_at(4)) || (ir_pc !== 6'd4) || (ir_valid !== 1'b1)) begin
        tests_failed++;
        $display("[TB] FAIL bp_hold_%0d: got ir=%0h pc=%0d v=%0b, want 10000004/4/1", s, ir, ir_pc, ir_valid);
      end
    end
    tests_run++;
    if (perf_stall_cnt !== 16'(3 * PERF_ON)) begin
      tests_failed++;
      $display("[TB] FAIL bp_perf_count: got %0d, want %0d", perf_stall_cnt, 3 * PERF_ON);
    end
    drain_accept();
    tests_run++;
    if ((acc_pc.size() != 8) || (acc_pc[0] != 4) || (acc_pc[1] != 5) || (acc_pc[7] != 11) ||
        (acc_ir[1] !== word_at(5)) || (reached_done !== 1'b1)) begin
      tests_failed++;
      $display("[TB] FAIL bp_sequence: got n=%0d first=%0d second=%0d done=%0b, want 8/4/5/1",
               acc_pc.size(), (acc_pc.size() > 0) ? acc_pc[0] : -1, (acc_pc.size() > 1) ? acc_pc[1] : -1, reached_done);
    end
    pulse_start();
    tests_run++;
    if (perf_stall_cnt !== 16'd0) begin
      tests_failed++;
      $display("[TB] FAIL perf_clear_on_start: got %0d, want 0", perf_stall_cnt);
    end
  endtask

  task automatic test_branch();
    bit found;
    do_reset();
    ir_ready = 1'b1;
    pulse_start();
    run_to_pc(7, found);
    tests_run++;
    if (found !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL br_reach_pc7: got found=%0b, want 1", found);
    end
    br_valid  = 1'b1;
    br_target = 6'd2;
    step();
    br_valid = 1'b0;
    tests_run++;
    if ((ir_valid !== 1'b0) || (rom_addr !== 6'd2) || (busy !== 1'b1)) begin
      tests_failed++;
      $display("[TB] FAIL br_bubble: got v=%0b addr=%0d busy=%0b, want 0/2/1", ir_valid, rom_addr, busy);
    end
    step();
    tests_run++;
    if ((ir_valid !== 1'b1) || (ir_pc !== 6'd2) || (ir !== word_at(2))) begin
      tests_failed++;
      $display("[TB] FAIL br_target_word: got v=%0b pc=%0d ir=%0h, want 1/2/10000002", ir_valid, ir_pc, ir);
    end
    drain_accept();
    tests_run++;
    if ((acc_pc.size() != 10) || (acc_pc[0] != 2) || (acc_pc[1] != 3) || (acc_pc[2] != 4) ||
        (acc_pc[9] != 11) || (reached_done !== 1'b1)) begin
      tests_failed++;
      $display("[TB] FAIL br_sequence: got n=%0d first=%0d done=%0b, want 10/2/1",
               acc_pc.size(), (acc_pc.size() > 0) ? acc_pc[0] : -1, reached_done);
    end
  endtask

  task automatic test_out_of_range();
    bit found;
    do_reset();
    ir_ready = 1'b1;
    pulse_start();
    run_to_pc(3, found);
    br_valid  = 1'b1;
    br_target = 6'd12;
    step();
    br_valid = 1'b0;
    tests_run++;
    if ((found !== 1'b1) || (ir_valid !== 1'b0) || (done !== 1'b1) || (busy !== 1'b0)) begin
      tests_failed++;
      $display("[TB] FAIL br_out_of_range: got found=%0b v=%0b done=%0b busy=%0b, want 1/0/1/0",
               found, ir_valid, done, busy);
    end
  endtask

  task automatic test_reset_mid_run();
    bit found;
    do_reset();
    ir_ready = 1'b1;
    pulse_start();
    run_to_pc(5, found);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    tests_run++;
    if ((found !== 1'b1) || (rom_addr !== '0) || (ir !== '0) || (ir_pc !== '0)) begin
      tests_failed++;
      $display("[TB] FAIL midrun_reset_data: got found=%0b addr=%0d ir=%0h pc=%0d, want 1/0/0/0",
               found, rom_addr, ir, ir_pc);
    end
    tests_run++;
    if ((ir_valid !== 1'b0) || (busy !== 1'b0) || (done !== 1'b0) || (perf_stall_cnt !== 16'd0)) begin
      tests_failed++;
      $display("[TB] FAIL midrun_reset_status: got v=%0b busy=%0b done=%0b perf=%0d, want 0/0/0/0",
               ir_valid, busy, done, perf_stall_cnt);
    end
    pulse_start();
    step();
    drain_accept();
    tests_run++;
    if ((acc_pc.size() != DEPTH) || (acc_pc[0] != 0) || (acc_ir[0] !== word_at(0)) || (acc_pc[5] != 5)) begin
      tests_failed++;
      $display("[TB] FAIL midrun_refetch: got n=%0d first=%0d, want %0d/0",
               acc_pc.size(), (acc_pc.size() > 0) ? acc_pc[0] : -1, DEPTH);
    end
  endtask

  task automatic test_restart();
    bit pulsed;
    do_reset();
    ir_ready = 1'b1;
    pulse_start();
    drain_accept();
    tests_run++;
    if (done !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL restart_first_done: got %0b, want 1", done);
    end
    pulse_start();
    tests_run++;
    if ((busy !== 1'b1) || (rom_addr !== 6'd0) || (done !== 1'b0)) begin
      tests_failed++;
      $display("[TB] FAIL restart_from_done: got busy=%0b addr=%0d done=%0b, want 1/0/0", busy, rom_addr, done);
    end
    acc_pc.delete();
    pulsed       = 1'b0;
    reached_done = 1'b0;
    for (int i = 0; i < 60; i++) begin
      if (done) begin
        reached_done = 1'b1;
        break;
      end
      if (ir_valid && ir_ready) acc_pc.push_back(int'(ir_pc));
      if (ir_valid && (ir_pc == 6'd6) && !pulsed) begin
        start  = 1'b1;
        pulsed = 1'b1;
      end
      step();
      start = 1'b0;
    end
    tests_run++;
    if ((acc_pc.size() != DEPTH) || (acc_pc[0] != 0) || (acc_pc[6] != 6) || (acc_pc[7] != 7) ||
        (acc_pc[11] != 11) || (reached_done !== 1'b1) || (pulsed !== 1'b1)) begin
      tests_failed++;
      $display("[TB] FAIL restart_busy_start: got n=%0d pc7=%0d done=%0b, want %0d/7/1",
               acc_pc.size(), (acc_pc.size() > 7) ? acc_pc[7] : -1, reached_done, DEPTH);
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, want completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst_n     = 1'b0;
    start     = 1'b0;
    ir_ready  = 1'b0;
    br_valid  = 1'b0;
    br_target = '0;
    max_addr  = 0;
    #1;
    test_reset();
    test_straight_line();
    test_back_pressure();
    test_branch();
    test_out_of_range();
    test_reset_mid_run();
    test_restart();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/fetch_sequencer.md
# fetch_sequencer

Instruction-fetch controller placed between the 6-bit-addressed program ROM and the decode stage. It owns the program counter, drives the ROM address, and captures returned words into a one-entry instruction register. It presents each word to decode with a valid/ready handshake, applies branch redirects from execute, and signals completion when the program runs off the end of the ROM.

## Interface
- `ADDR_W`, default 6: ROM address / PC width.
- `DATA_W`, default 32: instruction width.
- `ROM_DEPTH`, default 12: number of valid ROM words; addresses `>= ROM_DEPTH` mean end of program.
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst_n` in 1: reset, synchronous, active-low.
- `start` in 1: one-cycle pulse; starts fetch at address 0 from IDLE or DONE.
- `rom_addr` out ADDR_W: registered ROM address. The ROM samples it on the falling edge, so `rom_data` is stable at the next rising edge.
- `rom_data` in DATA_W: ROM read data.
- `ir` out DATA_W: current instruction.
- `ir_pc` out ADDR_W: address of `ir`.
- `ir_valid` out 1: `ir` holds an unconsumed instruction.
- `ir_ready` in 1: decode accepts `ir` this cycle when `ir_valid & ir_ready`.
- `br_valid` in 1: redirect request from execute.
- `br_target` in ADDR_W: redirect address.
- `busy` out 1: state is FETCH or DRAIN.
- `done` out 1: state is DONE.
- `perf_stall_cnt` out 16: cycles with `ir_valid & !ir_ready`. Functional only under the configuration macro.

## Operation
- States: IDLE, FETCH, DRAIN, DONE.
- Reset values: state IDLE; `rom_addr`=0; `ir`=0; `ir_pc`=0; `ir_valid`=0; `busy`=0; `done`=0; `perf_stall_cnt`=0.
- IDLE:
  - `start` → FETCH with `rom_addr`=0.
  - All other inputs ignored.
- FETCH, define `adv = !ir_valid | ir_ready`:
  - When `adv`: `ir`←`rom_data`, `ir_pc`←`rom_addr`, `ir_valid`←1.
  - If `rom_addr == ROM_DEPTH-1`, go to DRAIN; otherwise `rom_addr`←`rom_addr+1`.
  - When `!adv`: hold `ir`, `ir_pc`, `ir_valid` and `rom_addr`. The ROM re-reads the same word, which is harmless.
- DRAIN:
  - `ir_valid & ir_ready` → `ir_valid`←0, go to DONE.
- DONE:
  - `done`=1.
  - `start` → FETCH at address 0.
- Branch rule, in FETCH or DRAIN, with priority over all other actions:
  - `br_valid` → `ir_valid`←0. The wrong-path word is flushed and never accepted.
  - If `br_target < ROM_DEPTH`: `rom_addr`←`br_target`, go to FETCH.
  - Else: go to DONE.
- `br_valid` in IDLE or DONE is ignored.
- `start` while busy is ignored.
- `br_valid` and `ir_ready` in the same cycle: the handshake on the current `ir` still completes for decode, and the flush still applies.
- PC arithmetic is unsigned ADDR_W. Wrap-around cannot occur because advancing stops at `ROM_DEPTH-1`.

## Timing
- Fetch latency:
  - `start` at edge N → `rom_addr`=0 after N.
  - First `ir_valid` after edge N+1.
- Throughput: one instruction per cycle while `ir_ready`=1.
- Branch latency:
  - `br_valid` sampled at edge B → `ir_valid`=0 after B.
  - Target word valid after B+1: a one-bubble penalty.
- Back-pressure: `ir` and `ir_pc` stay stable while `ir_valid & !ir_ready`.
- `rst_n` low at any edge, including mid-FETCH or mid-DRAIN, forces all reset values at that edge. No partial state survives.

## Configuration
- `FETCH_SEQ_PERF_EN` defined:
  - `perf_stall_cnt` increments once per cycle of `ir_valid & !ir_ready` while busy.
  - It saturates at 16'hFFFF.
  - It clears on reset and on an accepted `start`.
- Not defined: the port is present and tied to 0, and no counter logic is synthesized.

## Structure
- Shared package `fetch_pkg` holds:
  - the `ADDR_W`, `DATA_W` and `ROM_DEPTH` defaults;
  - the state enum (IDLE=0, FETCH=1, DRAIN=2, DONE=3).
- One sub-module, `fetch_perf_counter`: 16-bit saturating counter with `inc` and `clr` inputs. It is instantiated only under `FETCH_SEQ_PERF_EN`.

## Test plan
The bench ROM model returns `word[i]=32'h1000_0000+i`, with a negedge read.
1. Straight line: reset, `start`, `ir_ready`=1 → `ir_pc` runs 0..11 with `ir`=32'h1000_0000..32'h1000_000B, one per cycle. Then `done`=1 one cycle after the last acceptance, and `rom_addr` never exceeds 11.
2. Back-pressure: `ir_ready`=0 for 3 cycles while `ir_pc`=4 → `ir` holds 32'h1000_0004. The next accepted word is 5, with no loss or duplication. With the macro, `perf_stall_cnt`=3.
3. Branch: `br_valid` with `br_target`=2 while `ir_pc`=7 → the word at 8 is never accepted, the next valid `ir_pc` is 2 after one bubble, and the sequence continues 3, 4, …
4. Out-of-range branch: `br_target`=12 → `ir_valid`=0 and `done`=1 on the next cycle.
5. Reset mid-run: `rst_n`=0 for one edge while `ir_pc`=5 → all outputs at reset values. A later `start` refetches from 0.
6. Restart: `start` in DONE → full sequence from 0. `start` pulsed while busy → no effect on the `ir_pc` sequence.
